// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: opcode and shift-control
// encodings understood by alu_simple, the arbiter FSM state encoding, the
// default datapath width and a helper that classifies an opcode/shift pair
// as one the ALU actually defines.
// Ports: none (package).
// Optional feature macro referenced by users of op_is_legal: ALU_ARBITER_OPCHK_EN
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DW = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    localparam logic [2:0] SR_NONE  = 3'b000;
    localparam logic [2:0] SR_RIGHT = 3'b001;
    localparam logic [2:0] SR_LEFT  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // A shift request ignores the opcode, so only an unshifted operation
    // needs a defined opcode.
    function automatic logic op_is_legal(input logic [3:0] opcode, input logic [2:0] sr_cont);
        if (sr_cont == SR_NONE) begin
            return opcode <= OP_XOR;
        end
        return (sr_cont == SR_RIGHT) || (sr_cont == SR_LEFT);
    endfunction

endpackage

// File: rtl/alu_simple.sv
// -----------------------------------------------------------------------------
// alu_simple
// Purely combinational ALU. Computes add/sub/mul/or/and/xor of in1_i and
// in2_i truncated to DW bits; a non-zero shift control replaces that result
// with in2_i shifted by sr_bit_i (undefined shift codes return in2_i as is).
// Ports:
//   opcode_i  [3:0]    operation select
//   sr_cont_i [2:0]    shift control (none/right/left)
//   sr_bit_i  [4:0]    shift amount
//   in1_i     [DW-1:0] first operand
//   in2_i     [DW-1:0] second operand, also the shifted value
//   out_o     [DW-1:0] result
// -----------------------------------------------------------------------------
module alu_simple
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW
) (
    input  logic [3:0]    opcode_i,
    input  logic [2:0]    sr_cont_i,
    input  logic [4:0]    sr_bit_i,
    input  logic [DW-1:0] in1_i,
    input  logic [DW-1:0] in2_i,
    output logic [DW-1:0] out_o
);

    logic [DW-1:0] arith;

    always_comb begin
        arith = '0;
        case (opcode_i)
            OP_ADD:  arith = in1_i + in2_i;
            OP_SUB:  arith = in1_i - in2_i;
            OP_MUL:  arith = in1_i * in2_i;
            OP_OR:   arith = in1_i | in2_i;
            OP_AND:  arith = in1_i & in2_i;
            OP_XOR:  arith = in1_i ^ in2_i;
            default: arith = '0;
        endcase

        // Shift control takes priority over the opcode result.
        out_o = arith;
        case (sr_cont_i)
            SR_NONE:  out_o = arith;
            SR_RIGHT: out_o = in2_i >> sr_bit_i;
            SR_LEFT:  out_o = in2_i << sr_bit_i;
            default:  out_o = in2_i;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter sharing one alu_simple between NUM_REQ requesters.
// The winner's payload is latched, the ALU settles for EXEC_CYCLES cycles,
// and the result is held on rsp_data until the granted requester accepts it.
// Optional feature macro: ALU_ARBITER_OPCHK_EN -- when defined, undefined
// opcode/shift combinations bypass the ALU and answer with rsp_err=1 and
// rsp_data=0; when undefined, rsp_err is tied low.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake
//   req_opcode/sr_cont/sr_bit  packed per-requester ALU controls
//   req_a/req_b                packed per-requester operands
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_data, rsp_err          shared response bus and illegal-op flag
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int EXEC_CYCLES = 1,
    parameter int DW          = ALU_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_opcode,
    input  logic [3*NUM_REQ-1:0]  req_sr_cont,
    input  logic [5*NUM_REQ-1:0]  req_sr_bit,
    input  logic [DW*NUM_REQ-1:0] req_a,
    input  logic [DW*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      gnt_q;
    logic [2:0]         exec_cnt_q;
    logic [3:0]         opcode_q;
    logic [2:0]         sr_cont_q;
    logic [4:0]         sr_bit_q;
    logic [DW-1:0]      a_q;
    logic [DW-1:0]      b_q;
    logic [DW-1:0]      rsp_data_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic [IW-1:0]      pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [3:0]         pick_opcode;
    logic [2:0]         pick_sr_cont;
    logic [4:0]         pick_sr_bit;
    logic [DW-1:0]      pick_a;
    logic [DW-1:0]      pick_b;
    logic [DW-1:0]      alu_out;

    // Index arithmetic modulo NUM_REQ; step never exceeds NUM_REQ-1, so a
    // single wrap is enough for any requester count, power of two or not.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx, input int step);
        int j;
        j = int'(idx) + step;
        if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
        end
        return IW'(j);
    endfunction

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] ptr);
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        logic          found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_inc(ptr, k);
            if (!found && v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick         = rr_pick(req_valid, rr_ptr_q);
    assign pick_oh      = NUM_REQ'(1) << pick;
    assign gnt_oh       = NUM_REQ'(1) << gnt_q;
    assign pick_opcode  = req_opcode[4*int'(pick) +: 4];
    assign pick_sr_cont = req_sr_cont[3*int'(pick) +: 3];
    assign pick_sr_bit  = req_sr_bit[5*int'(pick) +: 5];
    assign pick_a       = req_a[DW*int'(pick) +: DW];
    assign pick_b       = req_b[DW*int'(pick) +: DW];

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign req_ready = (state_q == IDLE && rst_n && (|req_valid)) ? pick_oh : '0;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    // The ALU only ever sees the latched payload, so requesters may change
    // their inputs as soon as the transfer edge has passed.
    alu_simple #(.DW(DW)) u_alu (
        .opcode_i  (opcode_q),
        .sr_cont_i (sr_cont_q),
        .sr_bit_i  (sr_bit_q),
        .in1_i     (a_q),
        .in2_i     (b_q),
        .out_o     (alu_out)
    );

`ifdef ALU_ARBITER_OPCHK_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            exec_cnt_q  <= '0;
            opcode_q    <= '0;
            sr_cont_q   <= '0;
            sr_bit_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
`ifdef ALU_ARBITER_OPCHK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_q     <= pick;
                        opcode_q  <= pick_opcode;
                        sr_cont_q <= pick_sr_cont;
                        sr_bit_q  <= pick_sr_bit;
                        a_q       <= pick_a;
                        b_q       <= pick_b;
`ifdef ALU_ARBITER_OPCHK_EN
                        // Undefined operations answer immediately without using the ALU.
                        if (!op_is_legal(pick_opcode, pick_sr_cont)) begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= pick_oh;
                            state_q     <= RESP;
                        end else
`endif
                        begin
                            exec_cnt_q <= 3'(EXEC_CYCLES - 1);
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (exec_cnt_q == 3'd0) begin
                        rsp_data_q  <= alu_out;
                        rsp_valid_q <= gnt_oh;
                        state_q     <= RESP;
                    end else begin
                        exec_cnt_q <= exec_cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
`ifdef ALU_ARBITER_OPCHK_EN
                        rsp_err_q   <= 1'b0;
`endif
                        rr_ptr_q    <= wrap_inc(gnt_q, 1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. One instance uses the default
// parameters (2 requesters, 1 exec cycle); a second uses EXEC_CYCLES=3 for
// the longer-latency and mid-operation reset sequences. Expected results
// come from a behavioural model of the ALU arithmetic and of round-robin
// fairness. Honours ALU_ARBITER_OPCHK_EN for the illegal-opcode response.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NR  = 2;
    localparam int EX  = 1;
    localparam int EX3 = 3;

`ifdef ALU_ARBITER_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic [1:0]  reqValid, reqReady, rspValid, rspReady;
    logic [7:0]  reqOpcode;
    logic [5:0]  reqSrCont;
    logic [9:0]  reqSrBit;
    logic [63:0] reqA, reqB;
    logic [31:0] rspData;
    logic        rspErr, busy;

    // EXEC_CYCLES=3 instance
    logic [1:0]  reqValid3, reqReady3, rspValid3, rspReady3;
    logic [7:0]  reqOpcode3;
    logic [5:0]  reqSrCont3;
    logic [9:0]  reqSrBit3;
    logic [63:0] reqA3, reqB3;
    logic [31:0] rspData3;
    logic        rspErr3, busy3;

    alu_arbiter #(.NUM_REQ(NR), .EXEC_CYCLES(EX), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_opcode(reqOpcode), .req_sr_cont(reqSrCont), .req_sr_bit(reqSrBit),
        .req_a(reqA), .req_b(reqB),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_data(rspData), .rsp_err(rspErr), .busy(busy)
    );

    alu_arbiter #(.NUM_REQ(NR), .EXEC_CYCLES(EX3), .DW(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid3), .req_ready(reqReady3),
        .req_opcode(reqOpcode3), .req_sr_cont(reqSrCont3), .req_sr_bit(reqSrBit3),
        .req_a(reqA3), .req_b(reqB3),
        .rsp_valid(rspValid3), .rsp_ready(rspReady3),
        .rsp_data(rspData3), .rsp_err(rspErr3), .busy(busy3)
    );

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [2:0]  src;
        logic [4:0]  sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expData;
        bit          expErr;
        bit          chkData;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    int checksTotal  = 0;
    int checksPassed = 0;
    int rrPtr        = 0;

    logic [3:0]  tOp[2];
    logic [2:0]  tSrc[2];
    logic [4:0]  tSb[2];
    logic [31:0] tA[2];
    logic [31:0] tB[2];

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Behavioural ALU: plain modular arithmetic on 64-bit values
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [2:0] src,
                                           input logic [4:0] sb, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, x, y, p2;
        m  = 64'h1_0000_0000;
        x  = {32'd0, a};
        y  = {32'd0, b};
        p2 = 64'd1 << sb;
        if (src == 3'd1) return 32'(y / p2);
        if (src == 3'd2) return 32'((y * p2) % m);
        if (src != 3'd0) return b;
        case (op)
            4'd0:    return 32'((x + y) % m);
            4'd1:    return 32'((x + m - y) % m);
            4'd2:    return 32'((x * y) % m);
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit refIllegal(input logic [3:0] op, input logic [2:0] src);
        return (src == 3'd0 && op > 4'd5) || (src > 3'd2);
    endfunction

    // Fairness model: first requesting port counting up from the pointer
    function automatic int refPick(input logic [1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    task automatic driveRequest(input logic [1:0] mask);
        for (int p = 0; p < NR; p++) begin
            reqOpcode[4*p +: 4]  = tOp[p];
            reqSrCont[3*p +: 3]  = tSrc[p];
            reqSrBit[5*p +: 5]   = tSb[p];
            reqA[32*p +: 32]     = tA[p];
            reqB[32*p +: 32]     = tB[p];
        end
        reqValid = mask;
    endtask

    // One full transaction on the default instance; entered #1 after a posedge with the DUT idle
    task automatic applyStimulus(input logic [1:0] mask, input int expG, input logic [31:0] expData,
                                 input bit expErr, input bit chkData, input int holdCycles);
        int         lat;
        logic [1:0] gOh;
        gOh = 2'(1 << expG);
        driveRequest(mask);
        @(negedge clk);
        checkOutput("req_ready grant", {62'd0, reqReady}, {62'd0, gOh});
        checkOutput("busy idle", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        reqValid = '0;
        lat = 1;
        while (rspValid == 2'b00 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), expErr ? 64'd1 : 64'(EX + 1));
        checkOutput("rsp_valid", {62'd0, rspValid}, {62'd0, gOh});
        if (chkData) checkOutput("rsp_data", {32'd0, rspData}, {32'd0, expData});
        checkOutput("rsp_err", {63'd0, rspErr}, {63'd0, expErr});
        for (int d = 0; d < holdCycles; d++) begin
            rspReady = 2'($urandom) & ~gOh;
            reqValid = 2'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold rsp_valid", {62'd0, rspValid}, {62'd0, gOh});
            if (chkData) checkOutput("hold rsp_data", {32'd0, rspData}, {32'd0, expData});
            checkOutput("hold busy", {63'd0, busy}, 64'd1);
            checkOutput("hold req_ready", {62'd0, reqReady}, 64'd0);
        end
        reqValid = '0;
        rspReady = gOh | 2'($urandom);
        @(posedge clk);
        #1;
        rspReady = '0;
        checkOutput("rsp_valid cleared", {62'd0, rspValid}, 64'd0);
        checkOutput("rsp_err cleared", {63'd0, rspErr}, 64'd0);
        checkOutput("busy cleared", {63'd0, busy}, 64'd0);
        rrPtr = (expG + 1) % NR;
    endtask

    initial begin
        int         g, lat, w;
        logic [1:0] mask;
        logic [31:0] ed;
        bit         ee;

        // Directed vectors: {port, op, sr_cont, sr_bit, a, b, data, err, check data, hold cycles}
        vecs[0]  = '{0, 4'd0, 3'b000, 5'd0, 32'd15,        32'd20,        32'd35,        1'b0, 1'b1, 0};
        vecs[1]  = '{1, 4'd1, 3'b000, 5'd0, 32'd30,        32'd10,        32'd20,        1'b0, 1'b1, 1};
        vecs[2]  = '{0, 4'd2, 3'b000, 5'd0, 32'd5,         32'd5,         32'd25,        1'b0, 1'b1, 0};
        vecs[3]  = '{0, 4'd5, 3'b000, 5'd0, 32'h0FF,       32'h0F0,       32'h00F,       1'b0, 1'b1, 5};
        vecs[4]  = '{1, 4'd0, 3'b001, 5'd4, 32'hDEADBEEF,  32'h12345678,  32'h01234567,  1'b0, 1'b1, 0};
        vecs[5]  = '{0, 4'd3, 3'b010, 5'd4, 32'h11111111,  32'h12345678,  32'h23456780,  1'b0, 1'b1, 2};
        vecs[6]  = '{1, 4'd2, 3'b001, 5'd0, 32'h00000007,  32'h12345678,  32'h12345678,  1'b0, 1'b1, 0};
        vecs[7]  = '{0, 4'd1, 3'b000, 5'd0, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b1, 0};
        vecs[8]  = '{1, 4'd2, 3'b000, 5'd0, 32'h00010000,  32'h00010000,  32'h00000000,  1'b0, 1'b1, 1};
        vecs[9]  = '{0, 4'd3, 3'b000, 5'd0, 32'h0000F0F0,  32'h00000F00,  32'h0000FFF0,  1'b0, 1'b1, 0};
        vecs[10] = '{1, 4'd4, 3'b000, 5'd0, 32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0, 1'b1, 0};
        vecs[11] = '{0, 4'hA, 3'b000, 5'd0, 32'd3,         32'd4,         32'd0,         OPCHK, OPCHK, 1};

        // Reset with requests pending: nothing may be granted or reported
        rst_n     = 1'b0;
        reqValid  = 2'b11;  rspReady  = '0;
        reqOpcode = '0; reqSrCont = '0; reqSrBit = '0; reqA = '0; reqB = '0;
        reqValid3 = '0;     rspReady3 = '0;
        reqOpcode3 = '0; reqSrCont3 = '0; reqSrBit3 = '0; reqA3 = '0; reqB3 = '0;
        #3;
        checkOutput("reset req_ready", {62'd0, reqReady}, 64'd0);
        checkOutput("reset rsp_valid", {62'd0, rspValid}, 64'd0);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset rsp_data", {32'd0, rspData}, 64'd0);
        checkOutput("reset rsp_err", {63'd0, rspErr}, 64'd0);
        reqValid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rrPtr = 0;
        @(posedge clk);
        #1;

        // Table-driven directed vectors, one requester at a time
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < NR; p++) begin
                tOp[p] = '0; tSrc[p] = '0; tSb[p] = '0; tA[p] = '0; tB[p] = '0;
            end
            tOp[vecs[i].port]  = vecs[i].op;
            tSrc[vecs[i].port] = vecs[i].src;
            tSb[vecs[i].port]  = vecs[i].sb;
            tA[vecs[i].port]   = vecs[i].a;
            tB[vecs[i].port]   = vecs[i].b;
            applyStimulus(2'(1 << vecs[i].port), vecs[i].port, vecs[i].expData,
                          vecs[i].expErr, vecs[i].chkData, vecs[i].hold);
        end

        // Contention: both ports request continuously right after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rrPtr = 0;
        @(posedge clk);
        #1;
        tOp[0] = 4'd1; tSrc[0] = '0; tSb[0] = '0; tA[0] = 32'd30; tB[0] = 32'd10;
        tOp[1] = 4'd2; tSrc[1] = '0; tSb[1] = '0; tA[1] = 32'd5;  tB[1] = 32'd5;
        driveRequest(2'b11);
        rspReady = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = refPick(2'b11, rrPtr);
            w = 0;
            @(negedge clk);
            while (reqReady == 2'b00 && w < 10) begin
                @(negedge clk);
                w++;
            end
            checkOutput("contention grant", {62'd0, reqReady}, 64'(1 << g));
            @(posedge clk);
            #1;
            lat = 1;
            while (rspValid == 2'b00 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput("contention rsp_valid", {62'd0, rspValid}, 64'(1 << g));
            checkOutput("contention rsp_data", {32'd0, rspData}, (g == 0) ? 64'd20 : 64'd25);
            @(posedge clk);
            #1;
            rrPtr = (g + 1) % NR;
        end
        reqValid = '0;
        rspReady = '0;
        @(posedge clk);
        #1;

        // Randomized traffic checked against the behavioural model
        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < NR; p++) begin
                tOp[p]  = OPCHK ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
                if ($urandom_range(0, 3) == 0) begin
                    tSrc[p] = OPCHK ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
                end else begin
                    tSrc[p] = 3'd0;
                end
                tSb[p] = 5'($urandom);
                tA[p]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                tB[p]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            end
            g  = refPick(mask, rrPtr);
            ee = OPCHK && refIllegal(tOp[g], tSrc[g]);
            ed = ee ? 32'd0 : refAlu(tOp[g], tSrc[g], tSb[g], tA[g], tB[g]);
            applyStimulus(mask, g, ed, ee, 1'b1, $urandom_range(0, 3));
        end

        // Longer execution: port 1 multiply on the EXEC_CYCLES=3 instance
        reqOpcode3[7:4] = 4'd2; reqA3[63:32] = 32'd6; reqB3[63:32] = 32'd7;
        reqValid3 = 2'b10;
        @(negedge clk);
        checkOutput("dut3 accept", {62'd0, reqReady3}, 64'd2);
        @(posedge clk);
        #1;
        reqValid3 = '0;
        lat = 1;
        while (rspValid3 == 2'b00 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("dut3 latency", 64'(lat), 64'(EX3 + 1));
        checkOutput("dut3 rsp_data", {32'd0, rspData3}, 64'd42);
        rspReady3 = 2'b10;
        @(posedge clk);
        #1;
        rspReady3 = '0;
        checkOutput("dut3 rsp_valid cleared", {62'd0, rspValid3}, 64'd0);

        // Reset during the second EXEC cycle abandons the transaction
        reqOpcode3[3:0] = 4'd0; reqA3[31:0] = 32'd1; reqB3[31:0] = 32'd2;
        reqValid3 = 2'b01;
        @(negedge clk);
        checkOutput("dut3 second accept", {62'd0, reqReady3}, 64'd1);
        @(posedge clk);
        #1;
        reqValid3 = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        reqValid3 = 2'b10;
        #1;
        checkOutput("mid-exec reset rsp_valid", {62'd0, rspValid3}, 64'd0);
        checkOutput("mid-exec reset busy", {63'd0, busy3}, 64'd0);
        checkOutput("mid-exec reset req_ready", {62'd0, reqReady3}, 64'd0);
        checkOutput("mid-exec reset rsp_data", {32'd0, rspData3}, 64'd0);
        checkOutput("mid-exec reset rsp_err", {63'd0, rspErr3}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rrPtr = 0;
        #1;
        checkOutput("post-reset accept", {62'd0, reqReady3}, 64'd2);
        @(posedge clk);
        #1;
        reqValid3 = '0;
        for (int e = 1; e <= EX3; e++) begin
            checkOutput("no stale response", {62'd0, rspValid3}, 64'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("post-reset rsp_valid", {62'd0, rspValid3}, 64'd2);
        checkOutput("post-reset rsp_data", {32'd0, rspData3}, 64'd42);
        rspReady3 = 2'b10;
        @(posedge clk);
        #1;
        rspReady3 = '0;
        checkOutput("post-reset busy cleared", {63'd0, busy3}, 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
